// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: debounces start/lap keys into press events and sequences
// the counter enable/clear and display hold through IDLE/RUN/PAUSE/LAP.

module stopwatch_ctrl_db #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_ni,
  output logic press_o
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          deb_q, deb_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          flip;

  assign flip = (sync2_q != deb_q) && (cnt_q == CMAX);

  always_comb begin
    cnt_d = '0;
    deb_d = deb_q;
    if (sync2_q != deb_q) begin
      if (flip) deb_d = sync2_q;
      else      cnt_d = cnt_q + 1'b1;
    end
  end

  // Pulse coincides with the edge that drops the debounced level, so the FSM acts on that edge.
  assign press_o = flip && !sync2_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      deb_q   <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= key_ni;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

module stopwatch_ctrl #(
  parameter int               WIDTH           = 16,
  parameter logic [WIDTH-1:0] MAX_COUNT       = '1,
  parameter int               DEBOUNCE_CYCLES = 250000
) (
  input  logic             CLOCK_50,
  input  logic             rst_n,
  input  logic             key_start_n,
  input  logic             key_lap_n,
  input  logic             tick,
  input  logic [WIDTH-1:0] count,
  output logic             count_en,
  output logic             count_clr,
  output logic             disp_hold,
  output logic [1:0]       state,
  output logic             at_max
);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, LAP = 2'b11} state_e;

  state_e     state_q;
  logic       hold_q, clr_q, at_max_q;
  logic [1:0] key_n, press;
  logic       start_ev, lap_ev;

  assign key_n = {key_lap_n, key_start_n};

  for (genvar k = 0; k < 2; k++) begin : g_key
    stopwatch_ctrl_db #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk_i   (CLOCK_50),
      .rst_ni  (rst_n),
      .key_ni  (key_n[k]),
      .press_o (press[k])
    );
  end

  assign start_ev = press[0];
  assign lap_ev   = press[1];

  // Saturation beats keys in RUN/LAP; start beats lap everywhere.
  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      hold_q   <= 1'b0;
      clr_q    <= 1'b1;
      at_max_q <= 1'b0;
    end else begin
      clr_q    <= 1'b0;
      hold_q   <= 1'b0;
      at_max_q <= (count == MAX_COUNT);
      case (state_q)
        IDLE:  if (start_ev) state_q <= RUN;
        RUN: begin
          if (at_max_q || start_ev) state_q <= PAUSE;
          else if (lap_ev) begin
            state_q <= LAP;
            hold_q  <= 1'b1;
          end
        end
        LAP: begin
          if (at_max_q || start_ev) state_q <= PAUSE;
          else if (lap_ev)          state_q <= RUN;
          else                      hold_q  <= 1'b1;
        end
        PAUSE: begin
          if (start_ev) state_q <= RUN;
          else if (lap_ev) begin
            state_q <= IDLE;
            clr_q   <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign count_en  = tick && (state_q == RUN || state_q == LAP) && !at_max_q;
  assign count_clr = clr_q;
  assign disp_hold = hold_q;
  assign state     = state_q;
  assign at_max    = at_max_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Randomized + directed bench for stopwatch_ctrl against a cycle-level behavioural model.

module tb_stopwatch_ctrl;
  localparam int DC = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, ks, kl, tk;
  logic [15:0] cnt;
  logic        en, clr, hold, am;
  logic [1:0]  st;

  stopwatch_ctrl #(.WIDTH(16), .MAX_COUNT(16'hFFFF), .DEBOUNCE_CYCLES(DC)) dut (
    .CLOCK_50    (clk),
    .rst_n       (rst_n),
    .key_start_n (ks),
    .key_lap_n   (kl),
    .tick        (tk),
    .count       (cnt),
    .count_en    (en),
    .count_clr   (clr),
    .disp_hold   (hold),
    .state       (st),
    .at_max      (am)
  );

  int n_vec = 0, n_err = 0, cyc = 0;
  bit tick_on = 0;

  // Model: 0 idle, 1 run, 2 pause, 3 lap
  int m_st;
  bit m_hold, m_clr, m_am;
  bit m_s1[2], m_s2[2], m_deb[2];
  int m_run[2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic mreset();
    m_st = 0; m_hold = 0; m_clr = 1; m_am = 0;
    for (int k = 0; k < 2; k++) begin
      m_s1[k] = 1; m_s2[k] = 1; m_deb[k] = 1; m_run[k] = 0;
    end
  endtask

  // Check outputs against model, advance model and DUT by one clock.
  task automatic step();
    bit pin[2];
    bit ev[2];
    #1;
    chk("state",    32'(st),   32'(m_st));
    chk("hold",     32'(hold), 32'(m_hold));
    chk("clr",      32'(clr),  32'(m_clr));
    chk("at_max",   32'(am),   32'(m_am));
    chk("count_en", 32'(en),   32'(tk && (m_st == 1 || m_st == 3) && !m_am));
    pin[0] = ks;
    pin[1] = kl;
    if (!rst_n) mreset();
    else begin
      // A level is accepted after DC consecutive cycles disagreeing with the accepted level.
      for (int k = 0; k < 2; k++) begin
        ev[k] = 0;
        if (m_s2[k] != m_deb[k]) begin
          m_run[k]++;
          if (m_run[k] == DC) begin
            m_deb[k] = m_s2[k];
            m_run[k] = 0;
            ev[k] = !m_deb[k];
          end
        end else m_run[k] = 0;
        m_s2[k] = m_s1[k];
        m_s1[k] = pin[k];
      end
      m_clr = 0;
      case (m_st)
        0: if (ev[0]) m_st = 1;
        1: if (m_am || ev[0]) m_st = 2; else if (ev[1]) m_st = 3;
        3: if (m_am || ev[0]) m_st = 2; else if (ev[1]) m_st = 1;
        default: if (ev[0]) m_st = 1; else if (ev[1]) begin m_st = 0; m_clr = 1; end
      endcase
      m_hold = (m_st == 3);
      m_am = (cnt == 16'hFFFF);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      tk = tick_on && (cyc % 5 == 0);
      step();
    end
  endtask

  task automatic press(input int which);
    if (which == 0) ks = 0; else kl = 0;
    cycles(DC + 4);
    if (which == 0) ks = 1; else kl = 1;
    cycles(DC + 4);
  endtask

  initial begin
    int lat;
    int hk[2];
    rst_n = 0; ks = 1; kl = 1; tk = 0; cnt = 16'h0;
    mreset();
    @(posedge clk);
    @(negedge clk);
    cycles(2);
    rst_n = 1;
    cycles(3);

    // Start latency from pin edge
    tick_on = 1;
    ks = 0;
    lat = 0;
    for (int i = 1; i <= 12 && lat == 0; i++) begin
      cycles(1);
      if (st == 2'b01) lat = i;
    end
    chk("start_lat", 32'(lat), 32'd6);
    cycles(3);
    ks = 1;
    cycles(12);

    // Bounce rejection, then one clean press
    ks = 0; cycles(2); ks = 1; cycles(2);
    ks = 0; cycles(2); ks = 1; cycles(8);
    chk("bounce_st", 32'(st), 32'd1);
    press(0);
    chk("clean_st", 32'(st), 32'd2);
    press(0);

    // Lap cycle
    press(1);
    chk("lap_st", 32'(st), 32'd3);
    chk("lap_hold", 32'(hold), 32'd1);
    press(1);
    chk("unlap_st", 32'(st), 32'd1);
    press(0);
    chk("pause_st", 32'(st), 32'd2);

    // Clear and lap-in-idle
    press(1);
    chk("clear_st", 32'(st), 32'd0);
    press(1);
    chk("idle_lap", 32'(st), 32'd0);

    // Saturation
    press(0);
    cnt = 16'hFFFF;
    cycles(1);
    chk("sat_am", 32'(am), 32'd1);
    cycles(1);
    chk("sat_st", 32'(st), 32'd2);
    cnt = 16'h0;
    cycles(2);
    press(0);

    // Simultaneous start and lap in RUN
    ks = 0; kl = 0; cycles(DC + 4);
    ks = 1; kl = 1; cycles(DC + 4);
    chk("both_st", 32'(st), 32'd2);

    // Random phase
    hk[0] = 0; hk[1] = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hk[0] == 0) begin ks = ~ks; hk[0] = $urandom_range(1, 12); end else hk[0]--;
      if (hk[1] == 0) begin kl = ~kl; hk[1] = $urandom_range(1, 12); end else hk[1]--;
      rst_n = ($urandom_range(0, 499) != 0);
      cnt = ($urandom_range(0, 39) == 0) ? 16'hFFFF : 16'($urandom);
      tk = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
